// File: rtl/fetch_align.sv
`default_nettype none
// ============================================================================
// Module   : fetch_align
// Purpose  : Word-aligned instruction fetch with a 4-halfword queue that hands
//            out whole 16/32-bit instructions, including word-straddling ones.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_align #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_valid,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_cmp,
    input  logic        instr_ready
);

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_WAIT = 2'd1,
        FS_DROP = 2'd2
    } fetch_state_t;

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [15:0] r_q      [4];
    logic [15:0] w_q_next [4];
    logic [2:0]  r_count;
    logic [2:0]  w_count_shift;
    logic [2:0]  w_count_next;
    logic [2:0]  w_consume;
    logic        r_skip_low;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_instr_pc;
    logic        w_q0_cmp;
    logic        w_has_instr;
    logic        w_fire;
    logic        w_push;

    // Delivery and request decisions, all from registered queue state.
    always_comb begin
        w_q0_cmp    = (r_q[0][1:0] != 2'b11);
        w_has_instr = w_q0_cmp ? (r_count >= 3'd1) : (r_count >= 3'd2);
        instr_valid = !redirect && w_has_instr;
        instr       = 32'h0;
        instr_cmp   = 1'b0;
        if (instr_valid) begin
            instr     = w_q0_cmp ? {16'h0, r_q[0]} : {r_q[1], r_q[0]};
            instr_cmp = w_q0_cmp;
        end
        w_fire        = instr_valid && instr_ready;
        w_consume     = w_fire ? (w_q0_cmp ? 3'd1 : 3'd2) : 3'd0;
        w_count_shift = r_count - w_consume;
        // Gated by rst_n so the strobe drops immediately on async reset.
        imem_valid    = rst_n && (r_state == FS_IDLE) && !redirect &&
                        (w_count_shift <= 3'd2);
        imem_addr     = r_fetch_pc;
        instr_pc      = r_instr_pc;
        w_push        = imem_ready && (r_state == FS_WAIT) && !redirect;
    end

    // Queue update: consume shifts first, then the response is appended.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_q_next[i] = r_q[i];
        end
        if (w_consume == 3'd1) begin
            w_q_next[0] = r_q[1];
            w_q_next[1] = r_q[2];
            w_q_next[2] = r_q[3];
            w_q_next[3] = 16'h0;
        end else if (w_consume == 3'd2) begin
            w_q_next[0] = r_q[2];
            w_q_next[1] = r_q[3];
            w_q_next[2] = 16'h0;
            w_q_next[3] = 16'h0;
        end
        for (int i = 0; i < 4; i++) begin
            if (w_push) begin
                if (r_skip_low) begin
                    if (w_count_shift == 3'(i)) w_q_next[i] = imem_rdata[31:16];
                end else begin
                    if (w_count_shift == 3'(i))        w_q_next[i] = imem_rdata[15:0];
                    if (w_count_shift + 3'd1 == 3'(i)) w_q_next[i] = imem_rdata[31:16];
                end
            end
        end
        if (redirect) begin
            w_count_next = 3'd0;
        end else if (w_push) begin
            w_count_next = w_count_shift + (r_skip_low ? 3'd1 : 3'd2);
        end else begin
            w_count_next = w_count_shift;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FS_IDLE: if (imem_valid) w_state_next = FS_WAIT;
            FS_WAIT: begin
                if (imem_ready)    w_state_next = FS_IDLE;
                else if (redirect) w_state_next = FS_DROP;
            end
            FS_DROP: if (imem_ready) w_state_next = FS_IDLE;
            default: w_state_next = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FS_IDLE;
            r_count    <= 3'd0;
            r_skip_low <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_instr_pc <= RESET_PC;
            for (int i = 0; i < 4; i++) begin
                r_q[i] <= 16'h0;
            end
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            for (int i = 0; i < 4; i++) begin
                r_q[i] <= w_q_next[i];
            end
            if (redirect) begin
                r_instr_pc <= {redirect_pc[31:1], 1'b0};
                r_fetch_pc <= {redirect_pc[31:2], 2'b00};
                r_skip_low <= redirect_pc[1];
            end else begin
                if (w_fire)     r_instr_pc <= r_instr_pc + {29'h0, w_consume, 1'b0};
                if (imem_valid) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_push)     r_skip_low <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
